// File: rtl/rtype_decode_unit_pkg.sv
// Shared pipeline selector enums, the decoded control bundle, and R-type funct codes
// used by the buffered R-type decode stage.
package selector;

  typedef enum logic [1:0] {
    PC_SRC_NEXT      = 2'd0,
    PC_SRC_EXECPTION = 2'd1,
    PC_SRC_REG       = 2'd2
  } pc_src_t;

  typedef enum logic [2:0] {
    EXC_CHK_NONE      = 3'd0,
    EXC_CHK_RESERVERD = 3'd1,
    EXC_CHK_SYSCALL   = 3'd2,
    EXC_CHK_BREAK     = 3'd3,
    EXC_CHK_OVERFLOW  = 3'd4
  } exc_chk_t;

  typedef enum logic [4:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU
  } alu_sel_t;

  typedef enum logic [1:0] {
    RD_SRC_ALU  = 2'd0,
    RD_SRC_HI   = 2'd1,
    RD_SRC_LO   = 2'd2,
    RD_SRC_LINK = 2'd3
  } rd_src_t;

endpackage

package signals;
  import selector::*;

  typedef struct packed {
    pc_src_t  pc_src;
    exc_chk_t exc_chk;
    alu_sel_t alu_sel;
    logic     reg_write;
    rd_src_t  rd_src;
    logic     hi_write;
    logic     lo_write;
    logic     muldiv;
  } control_t;

  function automatic control_t get_clear_control();
    control_t c;
    c.pc_src    = PC_SRC_NEXT;
    c.exc_chk   = EXC_CHK_NONE;
    c.alu_sel   = ALU_NONE;
    c.reg_write = 1'b0;
    c.rd_src    = RD_SRC_ALU;
    c.hi_write  = 1'b0;
    c.lo_write  = 1'b0;
    c.muldiv    = 1'b0;
    return c;
  endfunction

endpackage

package rtype;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;

  // Base funct set
  localparam logic [5:0] FUNCT_SLL     = 6'h00;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
  localparam logic [5:0] FUNCT_MFHI    = 6'h10;
  localparam logic [5:0] FUNCT_MTHI    = 6'h11;
  localparam logic [5:0] FUNCT_MFLO    = 6'h12;
  localparam logic [5:0] FUNCT_MTLO    = 6'h13;
  localparam logic [5:0] FUNCT_MULT    = 6'h18;
  localparam logic [5:0] FUNCT_MULTU   = 6'h19;
  localparam logic [5:0] FUNCT_DIV     = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU    = 6'h21;

  // Extended funct set
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_BREAK = 6'h0D;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

endpackage

// File: rtl/rtype_decode_unit_funct_decode.sv
// Combinational SPECIAL-opcode decoder: instruction word to control bundle.
module rtype_funct_decode
  import selector::*;
  import signals::*;
  import rtype::*;
#(
  parameter int unsigned EXT_ENABLE = 1
) (
  input  logic [31:0] instr,
  output control_t    ctl
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       reserved;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctl      = get_clear_control();
    reserved = 1'b0;
    if (opcode != OPCODE_SPECIAL) begin
      reserved = 1'b1;
    end else begin
      case (funct)
        FUNCT_SLL:     begin ctl.alu_sel = ALU_SLL; ctl.reg_write = 1'b1; end
        FUNCT_SYSCALL: begin ctl.pc_src = PC_SRC_EXECPTION; ctl.exc_chk = EXC_CHK_SYSCALL; end
        FUNCT_MFHI:    begin ctl.reg_write = 1'b1; ctl.rd_src = RD_SRC_HI; end
        FUNCT_MFLO:    begin ctl.reg_write = 1'b1; ctl.rd_src = RD_SRC_LO; end
        FUNCT_MTHI:    ctl.hi_write = 1'b1;
        FUNCT_MTLO:    ctl.lo_write = 1'b1;
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
          ctl.hi_write = 1'b1;
          ctl.lo_write = 1'b1;
          ctl.muldiv   = 1'b1;
          case (funct)
            FUNCT_MULT:  ctl.alu_sel = ALU_MULT;
            FUNCT_MULTU: ctl.alu_sel = ALU_MULTU;
            FUNCT_DIV:   ctl.alu_sel = ALU_DIV;
            default:     ctl.alu_sel = ALU_DIVU;
          endcase
        end
        FUNCT_ADDU:    begin ctl.alu_sel = ALU_ADD; ctl.reg_write = 1'b1; end
        default: begin
          // Extended functs fall through to reserved when the set is disabled
          if (EXT_ENABLE != 0) begin
            ctl.reg_write = 1'b1;
            case (funct)
              FUNCT_SRL:   ctl.alu_sel = ALU_SRL;
              FUNCT_SRA:   ctl.alu_sel = ALU_SRA;
              FUNCT_SLLV:  ctl.alu_sel = ALU_SLLV;
              FUNCT_SRLV:  ctl.alu_sel = ALU_SRLV;
              FUNCT_SRAV:  ctl.alu_sel = ALU_SRAV;
              FUNCT_ADD:   begin ctl.alu_sel = ALU_ADD; ctl.exc_chk = EXC_CHK_OVERFLOW; end
              FUNCT_SUB:   begin ctl.alu_sel = ALU_SUB; ctl.exc_chk = EXC_CHK_OVERFLOW; end
              FUNCT_SUBU:  ctl.alu_sel = ALU_SUB;
              FUNCT_AND:   ctl.alu_sel = ALU_AND;
              FUNCT_OR:    ctl.alu_sel = ALU_OR;
              FUNCT_XOR:   ctl.alu_sel = ALU_XOR;
              FUNCT_NOR:   ctl.alu_sel = ALU_NOR;
              FUNCT_SLT:   ctl.alu_sel = ALU_SLT;
              FUNCT_SLTU:  ctl.alu_sel = ALU_SLTU;
              FUNCT_JR:    begin ctl.pc_src = PC_SRC_REG; ctl.reg_write = 1'b0; end
              FUNCT_JALR:  begin ctl.pc_src = PC_SRC_REG; ctl.rd_src = RD_SRC_LINK; end
              FUNCT_BREAK: begin
                ctl.pc_src    = PC_SRC_EXECPTION;
                ctl.exc_chk   = EXC_CHK_BREAK;
                ctl.reg_write = 1'b0;
              end
              default:     reserved = 1'b1;
            endcase
          end else begin
            reserved = 1'b1;
          end
        end
      endcase
    end
    if (reserved) begin
      ctl         = get_clear_control();
      ctl.pc_src  = PC_SRC_EXECPTION;
      ctl.exc_chk = EXC_CHK_RESERVERD;
    end
  end

endmodule

// File: rtl/rtype_decode_unit.sv
// Buffered R-type decode stage: instruction queue, head decode, HI/LO hazard
// gating against an in-flight mul/div, and issue hold after an exception.
module rtype_decode_unit
  import selector::*;
  import signals::*;
#(
  parameter int unsigned QUEUE_DEPTH   = 4,
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned EXT_ENABLE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output control_t    out_ctl,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        muldiv_busy
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned MD_W  = $clog2(MULDIV_CYCLES + 1);

  logic [31:0]      instr_mem [QUEUE_DEPTH];
  logic [31:0]      pc_mem    [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [MD_W-1:0]  md_cnt;
  logic             exc_hold;

  logic     empty, full, push, pop, hilo_use, hazard;
  control_t head_ctl;

  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  rtype_funct_decode #(.EXT_ENABLE(EXT_ENABLE)) u_decode (
    .instr(out_instr),
    .ctl  (head_ctl)
  );

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(QUEUE_DEPTH));
  assign in_ready    = !full;
  assign muldiv_busy = (md_cnt != '0);
  assign hilo_use    = head_ctl.muldiv || head_ctl.hi_write || head_ctl.lo_write ||
                       (head_ctl.rd_src == RD_SRC_HI) || (head_ctl.rd_src == RD_SRC_LO);
  assign hazard      = hilo_use && muldiv_busy;
  assign out_valid   = !empty && !hazard && !exc_hold && !flush;
  assign out_ctl     = empty ? get_clear_control() : head_ctl;
  assign push        = in_valid && in_ready && !flush;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exc_hold <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      exc_hold <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop && head_ctl.pc_src == PC_SRC_EXECPTION) exc_hold <= 1'b1;
    end
  end

  // The in-flight operation completes regardless of flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (pop && head_ctl.muldiv) begin
      md_cnt <= MD_W'(MULDIV_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

endmodule
